// File: rtl/mux4_rr_sched_pkg.sv
// Purpose : shared definitions for the 4-source round-robin mux scheduler.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package mux4_rr_sched_pkg;

  // Scheduler states: IDLE owns nothing, BUSY has exactly one owner.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Number of sources sharing the lane.
  localparam int NSRC = 4;

endpackage

// File: rtl/mux4_rr_sched_data_mux.sv
// Purpose : 4:1 select mux for {last, data}; output forced to 0 when not enabled.
// Latency : purely combinational.
// Backpressure: none; it only steers whatever the selected source presents.
// Ports   : i_en (enable), i_sel (source index), i_data (packed words, source i
//           at [i*W +: W]), o_data (selected word or 0).
module rr_data_mux
  import mux4_rr_sched_pkg::*;
#(
  parameter int W = 9
) (
  input  logic              i_en,
  input  logic [1:0]        i_sel,
  input  logic [NSRC*W-1:0] i_data,
  output logic [W-1:0]      o_data
);

  always_comb begin
    o_data = '0;
    if (i_en) begin
      o_data = i_data[i_sel*W +: W];
    end
  end

endmodule

// File: rtl/mux4_rr_sched.sv
// Purpose : round-robin owner of a shared 4:1 output lane, grant held per packet.
// Latency : request at edge N -> grant after edge N; data path combinational while BUSY.
// Backpressure: out_ready gates the owner's in_ready; a stalled owner can be evicted by timeout.
// Ports   : req/in_data/in_last/in_ready per source; out_valid/out_data/out_last/out_ready
//           downstream; gnt (one-hot), out_src (mux select), timeout (forced-release pulse).
module mux4_rr_sched
  import mux4_rr_sched_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int MAX_CYC = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NSRC-1:0]        req,
  input  logic [NSRC*DATA_W-1:0] in_data,
  input  logic [NSRC-1:0]        in_last,
  output logic [NSRC-1:0]        in_ready,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_last,
  input  logic                   out_ready,
  output logic [1:0]             out_src,
  output logic [NSRC-1:0]        gnt,
  output logic                   timeout
);

  localparam int CNT_W = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYC - 1);
  localparam int MW = DATA_W + 1;

  state_t            r_state;
  logic [NSRC-1:0]   r_gnt;
  logic [1:0]        r_src;
  logic [1:0]        r_ptr;
  logic [CNT_W-1:0]  r_cnt;

  logic [NSRC*MW-1:0] w_mux_in;
  logic [MW-1:0]      w_mux_out;
  logic               w_busy;
  logic               w_rel_xfer;
  logic               w_timeout;
  logic               w_release;
  logic [1:0]         w_next_ptr;
  logic [2:0]         w_pick_idle;
  logic [2:0]         w_pick_rel;

  // First requester found searching p, p+1, ... mod 4. Returns {found, index}.
  // Walking from the far end down lets the nearest hit overwrite the others.
  function automatic logic [2:0] rr_pick(input logic [NSRC-1:0] r, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] idx;
    res = '0;
    for (int k = NSRC - 1; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

  for (genvar g = 0; g < NSRC; g++) begin : g_mux_in
    assign w_mux_in[g*MW +: MW] = {in_last[g], in_data[g*DATA_W +: DATA_W]};
  end

  assign w_busy = (r_state == BUSY);

  rr_data_mux #(.W(MW)) u_mux (
    .i_en   (w_busy),
    .i_sel  (r_src),
    .i_data (w_mux_in),
    .o_data (w_mux_out)
  );

  assign out_data  = w_mux_out[DATA_W-1:0];
  assign out_last  = w_mux_out[DATA_W];
  assign out_valid = w_busy & req[r_src];
  assign out_src   = r_src;
  assign gnt       = r_gnt;
  assign in_ready  = r_gnt & {NSRC{out_ready}};

  // A real end-of-packet transfer wins over the timeout in the same cycle.
  assign w_rel_xfer = out_valid & out_ready & out_last;
  assign w_timeout  = w_busy & (r_cnt == CNT_LAST) & ~w_rel_xfer;
  assign w_release  = w_rel_xfer | w_timeout;
  assign timeout    = w_timeout;

  // Re-arbitration on release starts just past the releasing source,
  // which puts that source at lowest priority.
  assign w_next_ptr  = r_src + 2'd1;
  assign w_pick_idle = rr_pick(req, r_ptr);
  assign w_pick_rel  = rr_pick(req, w_next_ptr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_src   <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pick_idle[2]) begin
            r_state <= BUSY;
            r_gnt   <= NSRC'(1) << w_pick_idle[1:0];
            r_src   <= w_pick_idle[1:0];
            r_cnt   <= '0;
          end
        end
        BUSY: begin
          if (w_release) begin
            r_ptr <= w_next_ptr;
            if (w_pick_rel[2]) begin
              // Hand-over in the same edge: no idle cycle between packets.
              r_gnt <= NSRC'(1) << w_pick_rel[1:0];
              r_src <= w_pick_rel[1:0];
              r_cnt <= '0;
            end else begin
              r_state <= IDLE;
              r_gnt   <= '0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_gnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux4_rr_sched.sv
// Purpose : self-checking bench for mux4_rr_sched with a beat scoreboard.
// Latency : n/a.
// Backpressure: out_ready driven per test; sources hold data until accepted.
module tb_mux4_rr_sched;

  logic        clk;
  logic        rst_n;

  // Main DUT (MAX_CYC=16), driven by a per-source packet model.
  logic [3:0]  req;
  logic [31:0] in_data;
  logic [3:0]  in_last;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_last;
  logic        out_ready;
  logic [1:0]  out_src;
  logic [3:0]  gnt;
  logic        timeout;

  // Timeout DUT (MAX_CYC=8), driven directly.
  logic [3:0]  req8;
  logic [31:0] in_data8;
  logic [3:0]  in_last8;
  logic [3:0]  in_ready8;
  logic        out_valid8;
  logic [7:0]  out_data8;
  logic        out_last8;
  logic        out_ready8;
  logic [1:0]  out_src8;
  logic [3:0]  gnt8;
  logic        timeout8;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [1:0] src;
    logic [7:0] dat;
    logic       lst;
  } beat_t;
  beat_t sb[$];

  // Source model state: bench-configured (en/plen/cfg_pkts), model-owned (bt/pk/done).
  logic [3:0] en;
  int         plen[4];
  int         cfg_pkts[4];
  logic [2:0] bt[4];
  logic [2:0] pk[4];
  int         done[4];
  logic [3:0] acc;
  logic [3:0] acc_last;

  mux4_rr_sched #(.DATA_W(8), .MAX_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .out_src(out_src), .gnt(gnt), .timeout(timeout)
  );

  mux4_rr_sched #(.DATA_W(8), .MAX_CYC(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .req(req8), .in_data(in_data8), .in_last(in_last8),
    .in_ready(in_ready8), .out_valid(out_valid8), .out_data(out_data8), .out_last(out_last8),
    .out_ready(out_ready8), .out_src(out_src8), .gnt(gnt8), .timeout(timeout8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign in_data8   = 32'h3322_1100;
  assign in_last8   = 4'b0000;
  assign out_ready8 = 1'b1;

  for (genvar g = 0; g < 4; g++) begin : g_src
    assign req[g]           = en[g] && (done[g] < cfg_pkts[g]);
    assign in_data[g*8 +: 8] = {2'(g), pk[g], bt[g]};
    assign in_last[g]       = (plen[g] != 0) && (bt[g] == 3'(plen[g] - 1));
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic exp_beat(input int src, input int p, input int b, input logic lst);
    beat_t e;
    e.src = 2'(src);
    e.dat = {2'(src), 3'(p), 3'(b)};
    e.lst = lst;
    sb.push_back(e);
  endtask

  // Monitor + source model: sample at negedge, advance sources just after posedge.
  always begin
    beat_t e;
    @(negedge clk);
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check_eq("sb_extra_beat", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        check_eq("sb_src",  32'(out_src),  32'(e.src));
        check_eq("sb_data", 32'(out_data), 32'(e.dat));
        check_eq("sb_last", 32'(out_last), 32'(e.lst));
      end
    end
    acc      = req & in_ready;
    acc_last = in_last;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (!rst_n) begin
        bt[i] = '0; pk[i] = '0; done[i] = 0;
      end else if (acc[i]) begin
        if (acc_last[i]) begin
          bt[i] = '0; pk[i] = pk[i] + 3'd1; done[i] = done[i] + 1;
        end else begin
          bt[i] = bt[i] + 3'd1;
        end
      end
    end
  end

  // Call just after a negedge; returns at negedge+1 with reset released.
  task automatic do_reset();
    #1;
    check_eq("sb_drain", 32'(sb.size()), 32'd0);
    sb.delete();
    rst_n     = 1'b0;
    en        = '0;
    req8      = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cfg_pkts[i] = 0;
      plen[i]     = 1;
    end
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1; en = '0; req8 = '0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cfg_pkts[i] = 0; plen[i] = 1; bt[i] = '0; pk[i] = '0; done[i] = 0;
    end
    #2 rst_n = 1'b0;

    // Reset values
    @(negedge clk);
    check_eq("rst_gnt",     32'(gnt),       32'd0);
    check_eq("rst_src",     32'(out_src),   32'd0);
    check_eq("rst_timeout", 32'(timeout),   32'd0);
    check_eq("rst_valid",   32'(out_valid), 32'd0);
    check_eq("rst_data",    32'(out_data),  32'd0);
    check_eq("rst_last",    32'(out_last),  32'd0);
    check_eq("rst_inready", 32'(in_ready),  32'd0);
    check_eq("rst_gnt8",    32'(gnt8),      32'd0);
    do_reset();

    // T1: all request, single-beat packets -> 0,1,2,3,0 back to back
    cfg_pkts[0] = 2; cfg_pkts[1] = 1; cfg_pkts[2] = 1; cfg_pkts[3] = 1;
    exp_beat(0, 0, 0, 1'b1); exp_beat(1, 0, 0, 1'b1); exp_beat(2, 0, 0, 1'b1);
    exp_beat(3, 0, 0, 1'b1); exp_beat(0, 1, 0, 1'b1);
    en = 4'hF;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_eq("t1_src",   32'(out_src),   32'(k % 4));
      check_eq("t1_valid", 32'(out_valid), 32'd1);
    end
    do_reset();

    // T2: 3-beat packet from src0 with src1 pending -> hand-over with no gap
    plen[0] = 3; cfg_pkts[0] = 1; plen[1] = 1; cfg_pkts[1] = 1;
    exp_beat(0, 0, 0, 1'b0); exp_beat(0, 0, 1, 1'b0); exp_beat(0, 0, 2, 1'b1);
    exp_beat(1, 0, 0, 1'b1);
    en = 4'b0011;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_eq("t2_gnt",   32'(gnt),       (k < 3) ? 32'h1 : 32'h2);
      check_eq("t2_valid", 32'(out_valid), 32'd1);
    end
    do_reset();

    // T3: sink stalls 5 cycles -> everything held, no timeout
    out_ready = 1'b0;
    plen[2] = 2; cfg_pkts[2] = 1;
    exp_beat(2, 0, 0, 1'b0); exp_beat(2, 0, 1, 1'b1);
    en = 4'b0100;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_eq("t3_gnt",     32'(gnt),       32'h4);
      check_eq("t3_data",    32'(out_data),  32'h80);
      check_eq("t3_timeout", 32'(timeout),   32'd0);
      check_eq("t3_inready", 32'(in_ready),  32'd0);
      check_eq("t3_valid",   32'(out_valid), 32'd1);
    end
    #1 out_ready = 1'b1;
    repeat (2) @(negedge clk);
    do_reset();

    // T4 (MAX_CYC=8): src2 streams without last, src3 waits -> forced release
    req8 = 4'b1100;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      check_eq("t4_gnt8",     32'(gnt8),     (k <= 8) ? 32'h4 : 32'h8);
      check_eq("t4_timeout8", 32'(timeout8), (k == 8) ? 32'd1 : 32'd0);
    end
    do_reset();

    // T5: reset mid-packet from src1, then restart from src0
    plen[1] = 4; cfg_pkts[1] = 1;
    exp_beat(1, 0, 0, 1'b0); exp_beat(1, 0, 1, 1'b0);
    en = 4'b0010;
    @(negedge clk);
    check_eq("t5_gnt_a", 32'(gnt), 32'h2);
    @(negedge clk);
    check_eq("t5_gnt_b", 32'(gnt), 32'h2);
    #1 rst_n = 1'b0;
    #1;
    check_eq("t5_rst_gnt",     32'(gnt),       32'd0);
    check_eq("t5_rst_valid",   32'(out_valid), 32'd0);
    check_eq("t5_rst_data",    32'(out_data),  32'd0);
    check_eq("t5_rst_last",    32'(out_last),  32'd0);
    check_eq("t5_rst_src",     32'(out_src),   32'd0);
    check_eq("t5_rst_inready", 32'(in_ready),  32'd0);
    for (int i = 0; i < 4; i++) begin
      plen[i] = 1; cfg_pkts[i] = 1;
    end
    en = 4'hF;
    exp_beat(0, 0, 0, 1'b1); exp_beat(1, 0, 0, 1'b1);
    exp_beat(2, 0, 0, 1'b1); exp_beat(3, 0, 0, 1'b1);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("t5_first_gnt", 32'(gnt), 32'h1);
    repeat (3) @(negedge clk);
    do_reset();

    // T6: only src3, three 2-beat packets -> grant never drops, no timeout
    plen[3] = 2; cfg_pkts[3] = 3;
    for (int p = 0; p < 3; p++) begin
      exp_beat(3, p, 0, 1'b0); exp_beat(3, p, 1, 1'b1);
    end
    en = 4'b1000;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check_eq("t6_gnt",     32'(gnt),       32'h8);
      check_eq("t6_valid",   32'(out_valid), 32'd1);
      check_eq("t6_timeout", 32'(timeout),   32'd0);
    end
    do_reset();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mux4_rr_sched.md
# mux4_rr_sched

Round-robin scheduler that shares one 4:1 select multiplexer between four packet sources and a single downstream sink. It arbitrates among requesters, drives the mux select from a registered grant, and holds the grant for a whole packet, delimited by `last`. It forces release on a cycle timeout. It sits directly in front of the shared output lane and replaces hard-wired select lines.

## Interface
- `DATA_W`, 8, width of each source data word
- `MAX_CYC`, 16, maximum cycles one grant may be held (≥2)
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  reset; asynchronous assert, active-low
- `req`  in  4  per-source request/valid
- `in_data`  in  4*DATA_W  source data, source i at bits [i*DATA_W +: DATA_W]
- `in_last`  in  4  per-source end-of-packet marker
- `in_ready`  out  4  per-source accept, equal to `gnt & {4{out_ready}}`
- `out_valid`  out  1  shared lane valid
- `out_data`  out  DATA_W  shared lane data
- `out_last`  out  1  shared lane end-of-packet
- `out_ready`  in  1  sink accept
- `out_src`  out  2  index of current owner, which is the mux select
- `gnt`  out  4  one-hot grant, registered
- `timeout`  out  1  one-cycle pulse on forced release

## Operation
- States: IDLE and BUSY. Round-robin pointer `ptr` (2 bits) gives the highest-priority index.
- Arbitration function: first i with req[i]=1, searching `ptr, ptr+1, ...` mod 4.
- IDLE:
  - `out_valid`=0 and `gnt`=0.
  - If any req, register the winner into `gnt`/`out_src` and go to BUSY. Otherwise stay in IDLE.
- BUSY datapath:
  - `out_valid`=req[src].
  - `out_data`=in_data[src].
  - `out_last`=in_last[src].
- Beat transfers when `out_valid & out_ready`.
- Release on a transfer with `out_last`=1:
  - `ptr` ← src+1 mod 4.
  - Re-arbitrate in the same cycle using the current `req`, with the releasing source at lowest priority.
  - If there is a winner, BUSY with the new grant and no bubble. If not, go to IDLE.
- Owner dropping req mid-packet: grant held, `out_valid`=0, and the timeout counter keeps running.
- Timeout counter `cnt`, width clog2(MAX_CYC):
  - Cleared on each new grant; increments every BUSY cycle.
  - If `cnt`==MAX_CYC-1 and no release transfer happens that cycle: forced release, identical to a normal release, and `timeout`=1 for that cycle.
  - A release transfer in that same cycle takes precedence, and `timeout` stays 0.
- Registered outputs have these reset values: `gnt`=0, `out_src`=0, `timeout`=0. Internal state resets to `ptr`=0, `cnt`=0, state IDLE.
- Reset has these effects on the remaining outputs:
  - `out_valid`=0, `out_last`=0, `out_data`=0 (IDLE masks the datapath to 0).
  - `in_ready`=0.

## Timing
- Request seen at edge N: grant visible after edge N, and the first beat can transfer in cycle N+1. Minimum latency is one cycle.
- Back-to-back packets from different sources: zero idle cycles between them.
- The datapath is combinational from `in_*` to `out_*` while BUSY. Only the control path is registered.
- Reset asserted mid-packet: all outputs go to reset values asynchronously. After deassertion, the scheduler restarts from IDLE with `ptr`=0.
- `gnt` is always one-hot or zero, and it changes only on a clock edge.

## Structure
- Shared header: state encoding (IDLE=0, BUSY=1) and the source-count constant 4.
- One sub-module, `rr_data_mux`: parameterised DATA_W+1-bit 4:1 select mux with output forced to 0 when not enabled. It carries data and last.
- The top level holds the FSM, pointer, counter and arbitration function.

## Test plan
- All four req=1, every packet single-beat, out_ready=1 → out_src sequence 0,1,2,3,0 on consecutive cycles; first beat one cycle after req.
- req0 sends a 3-beat packet (last on beat 3) while req1 is pending → gnt=0001 for 3 cycles, then 0010 on the next cycle with no gap.
- BUSY with out_ready=0 for 5 cycles, MAX_CYC=16 → out_data stable, gnt unchanged, timeout=0, in_ready=0.
- MAX_CYC=8, req2 streams without last, req3 pending → timeout pulse in the 8th BUSY cycle, then gnt=1000 on the next cycle.
- rst_n low mid-packet from source 1 → outputs zero immediately; after release with all req=1, source 0 is granted first.
- Only req3 active, three 2-beat packets → gnt stays 1000 throughout with no IDLE cycle, and timeout never fires.
